// File: rtl/mem_pkg.sv
// mem_pkg: cache/memory transaction types and arbiter enums shared by the L1 memory path
package mem_pkg;
  localparam int ADDR_W = 32;
  localparam int BLK_W = 128;
  typedef struct packed {
    logic Valid;
    logic Wen;
    logic [ADDR_W-1:0] Addr;
    logic [BLK_W-1:0] WriteD;
  } CacheToMem_t;
  typedef struct packed {
    logic Ready;
    logic [BLK_W-1:0] ReadD;
  } MemToCache_t;
  localparam int REQ_W = $bits(CacheToMem_t);
  localparam int RSP_W = $bits(MemToCache_t);
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_INS, ARB_GNT_DAT} arb_state_t;
  typedef enum logic {GRANT_INS, GRANT_DAT} arb_grant_t;
endpackage

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: grants the single memory port to the L1 data or instruction cache, data first with an instr anti-starvation limit
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   InsReq_i  : instr cache request        InsResp_o : response to instr cache
//   DatReq_i  : data cache request         DatResp_o : response to data cache
//   MemReq_o  : request to main memory     MemResp_i : main-memory response
module l1_mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [REQ_W-1:0] InsReq_i,
  output logic [RSP_W-1:0] InsResp_o,
  input  logic [REQ_W-1:0] DatReq_i,
  output logic [RSP_W-1:0] DatResp_o,
  output logic [REQ_W-1:0] MemReq_o,
  input  logic [RSP_W-1:0] MemResp_i
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  CacheToMem_t ins_req, dat_req;
  MemToCache_t mem_rsp, ins_rsp, dat_rsp;
  arb_state_t state_q, state_d;
  arb_grant_t grant;
  logic [CNT_W-1:0] starve_q, starve_d;
  assign ins_req = InsReq_i;
  assign dat_req = DatReq_i;
  assign mem_rsp = MemResp_i;
  // Data wins unless the instr side has already waited through LIMIT data grants.
  assign grant = dat_req.Valid && !(ins_req.Valid && starve_q == LIMIT) ? GRANT_DAT : GRANT_INS;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
    end
  end
  // The grant stays locked until memory Ready; Ready seen in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (ins_req.Valid || dat_req.Valid) begin
        state_d = grant == GRANT_DAT ? ARB_GNT_DAT : ARB_GNT_INS;
        starve_d = grant == GRANT_DAT && ins_req.Valid ? (starve_q == LIMIT ? LIMIT : starve_q + 1'b1) : '0;
      end
    end else if (mem_rsp.Ready) begin
      state_d = ARB_IDLE;
    end
  end
  assign MemReq_o = state_q == ARB_GNT_DAT ? dat_req : state_q == ARB_GNT_INS ? ins_req : CacheToMem_t'('0);
  // ReadD is broadcast; only the granted side ever sees Ready.
  assign ins_rsp = '{Ready: state_q == ARB_GNT_INS && mem_rsp.Ready, ReadD: mem_rsp.ReadD};
  assign dat_rsp = '{Ready: state_q == ARB_GNT_DAT && mem_rsp.Ready, ReadD: mem_rsp.ReadD};
  assign InsResp_o = ins_rsp;
  assign DatResp_o = dat_rsp;
  dat_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni) state_q == ARB_GNT_DAT |-> dat_req.Valid);
  ins_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni) state_q == ARB_GNT_INS |-> ins_req.Valid);
  ins_rd_only_a: assert property (@(posedge clk_i) disable iff (!rst_ni) ins_req.Valid |-> !ins_req.Wen);
endmodule
